seq_bin_to_bcd: RTL and testbench
=================================

// Module: seq_bin_to_bcd
// PURPOSE
//   Multi-cycle, parametrised binary-to-BCD converter using double-dabble (shift/add-3), one bit per clock.
//   Successor to the fixed 8-bit combinational converter: arbitrary WIDTH/DIGITS, start/done handshake, overflow flag.
//   Sits between the HR/SpO2 result registers and the seven-segment/display drivers.
//   One shared instance can serve several values by time-multiplexing.
// PARAMETERS
//   WIDTH   8  binary input width, >=1
//   DIGITS  3  BCD output digits; bcd width = 4*DIGITS
//   CNT_W   $clog2(WIDTH+1)  bit-counter width (localparam, not overridable)
// PORTS
//   clk    in   1         system clock, rising edge
//   rst    in   1         asynchronous reset, active-high
//   start  in   1         request conversion of bin; sampled only in IDLE
//   bin    in   WIDTH     unsigned binary value; captured on accepted start
//   busy   out  1         high while a conversion is in progress (SHIFT state)
//   done   out  1         one-cycle pulse: bcd/ovf valid and updated
//   bcd    out  4*DIGITS  packed BCD, digit 0 in [3:0]; held until the next done
//   ovf    out  1         bin >= 10**DIGITS; bcd then holds value mod 10**DIGITS
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, busy=0, done=0, bcd=0, ovf=0, internal shift regs/counter=0.
//   FSM: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: start=1 at edge E -> load bin into bin_sr, clear digit_sr and ovf accumulator, cnt=WIDTH, go SHIFT.
//   SHIFT: each edge: for each digit, if >=5 add 3 (combinational), then shift {digit_sr,bin_sr} left 1.
//     Bit leaving the top digit is ORed into the ovf accumulator. cnt decrements. At cnt==1 go DONE.
//   DONE: at that edge, bcd<=digit_sr and ovf<=accumulator. done=1 for exactly this one cycle, then IDLE.
//   Latency: done asserted in the cycle after edge E+WIDTH+1; bcd valid from the same cycle.
//   busy is high for exactly WIDTH cycles; done and busy are never high together.
//   Throughput: next start accepted in the cycle done is high, or later (IDLE re-entered after DONE).
//     done and busy never overlap.
//   start while SHIFT/DONE: ignored, not queued. bin changes after capture: no effect.
//   start held high continuously: back-to-back conversions, one per WIDTH+2 cycles.
//   Digits: add-3 per digit is unsigned 4-bit; correction never produces a digit >9 after the shift.
//   WIDTH=1: single SHIFT cycle; 0->0x0, 1->0x1.
//   DIGITS larger than needed: upper digits read 0; ovf never set.
//   Reset mid-conversion: abort; no done pulse; bcd returns to 0.
// CONFIGURATION
//   BIN2BCD_BLANK_EN defined:
//     - At DONE, leading-zero digits (from MSD down) are replaced by 4'hF (display blank code).
//     - Digit 0 is never blanked; a value of 0 shows as ...F0.
//     - Blanking is applied to the registered bcd; ovf is unaffected.
//   BIN2BCD_BLANK_EN undefined: leading zeros are output as 4'h0; no blanking logic is synthesised.
// TESTING
//   1. WIDTH=8, DIGITS=3, bin=255, start 1 cycle -> done 10 cycles later, bcd=12'h255, ovf=0, busy high 8 cycles.
//   2. bin=0 -> bcd=12'h000; with BIN2BCD_BLANK_EN, bin=0 -> 12'hFF0 and bin=99 -> 12'hF99.
//   3. WIDTH=10, DIGITS=3, bin=1000 -> ovf=1, bcd=12'h000; bin=999 -> ovf=0, bcd=12'h999.
//   4. start=1 with bin=17, then pulse start with bin=42 mid-SHIFT -> only one done, bcd=12'h017.
//   5. Assert rst at cycle 4 of a conversion of 200 -> no done, bcd=0, busy=0; next start bin=200 -> 12'h200.
//   6. Exhaustive 0..255 with start tied high vs integer reference model; check spacing of 10 cycles between dones.

Source files
------------

// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: multi-cycle binary-to-BCD converter (double-dabble,
// one input bit per clock) with start/done handshake and overflow flag.
// Optional feature macro: BIN2BCD_BLANK_EN -- leading-zero digits of the
// registered result are replaced by 4'hF (display blank code).
module seq_bin_to_bcd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BW    = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
    logic [BW-1:0]     digit_sr_q, digit_sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              acc_q, acc_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [BW-1:0]     adj;

`ifdef BIN2BCD_BLANK_EN
    // Blank leading zero digits from the MSD downward; digit 0 always shown.
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        logic lead;
        blank_lz = v;
        lead     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && (v[4*i +: 4] == 4'h0)) begin
                blank_lz[4*i +: 4] = 4'hF;
            end else begin
                lead = 1'b0;
            end
        end
    endfunction
`else
    // Leading zeros pass through unchanged.
    function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] v);
        blank_lz = v;
    endfunction
`endif

    // Add-3 correction on every digit that is >= 5, ahead of the shift.
    always_comb begin
        adj = digit_sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_sr_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = digit_sr_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath updates for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d    = state_q;
        bin_sr_d   = bin_sr_q;
        digit_sr_d = digit_sr_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sr_d   = bin;
                    digit_sr_d = '0;
                    acc_d      = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // A bit carried out of the top digit means value >= 10**DIGITS.
                {digit_sr_d, bin_sr_d} = {adj[BW-2:0], bin_sr_q, 1'b0};
                acc_d = acc_q | adj[BW-1];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d   = blank_lz(digit_sr_q);
                ovf_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_sr_q   <= '0;
            digit_sr_q <= '0;
            cnt_q      <= '0;
            acc_q      <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_sr_q   <= bin_sr_d;
            digit_sr_q <= digit_sr_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: scoreboard on an 8-bit/3-digit instance plus
// direct checks on a 10-bit/3-digit instance for overflow behaviour.
module tb_seq_bin_to_bcd;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, busy1, done1, ovf1;
    logic [7:0]  bin1;
    logic [11:0] bcd1;
    logic        start2, busy2, done2, ovf2;
    logic [9:0]  bin2;
    logic [11:0] bcd2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [11:0] bcd;
        logic        ovf;
    } exp_t;

    typedef struct {
        int          bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    exp_t sb[$];

    seq_bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .bin(bin1),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );

    seq_bin_to_bcd #(.WIDTH(10), .DIGITS(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] blank_fn(input logic [11:0] v);
        logic [11:0] r;
        r = v;
`ifdef BIN2BCD_BLANK_EN
        if (v[11:8] == 4'h0) begin
            r[11:8] = 4'hF;
            if (v[7:4] == 4'h0) r[7:4] = 4'hF;
        end
`endif
        return r;
    endfunction

    function automatic exp_t model(input int v);
        exp_t e;
        int   m;
        m     = v % 1000;
        e.bcd = blank_fn({4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)});
        e.ovf = (v >= 1000);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Scoreboard monitor: pops one expectation per done pulse.
    int busy_cnt   = 0;
    int last_done  = -1;
    bit spacing_en = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (done1) begin
                    chk("done_busy_overlap", {31'd0, busy1}, 32'd0);
                    chk("busy_cycles", busy_cnt, 8);
                    busy_cnt = 0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done actual bcd=%h ovf=%b required no done", bcd1, ovf1);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_result", {19'd0, bcd1, ovf1}, {19'd0, e.bcd, e.ovf});
                    end
                    if (spacing_en) begin
                        if (last_done >= 0) chk("done_spacing", cyc - last_done, 10);
                        last_done = cyc;
                    end
                end
                if (busy1) busy_cnt++;
            end
        end
    end

    // One conversion on dut1 with latency check; returns in the done cycle.
    task automatic run1(input int v, input exp_t e);
        int  c0;
        bit  got;
        bin1   = 8'(v);
        start1 = 1'b1;
        sb.push_back(e);
        c0  = cyc;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL run1_timeout actual no done required done for bin=%0d", v);
        end else begin
            chk("latency", cyc - c0, 10);
        end
    endtask

    task automatic run2(input int v, input logic [11:0] eb, input logic eo);
        bit got;
        bin2   = 10'(v);
        start2 = 1'b1;
        got    = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL run2_timeout actual no done required done for bin=%0d", v);
        end else begin
            chk("w10_bcd", {20'd0, bcd2}, {20'd0, blank_fn(eb)});
            chk("w10_ovf", {31'd0, ovf2}, {31'd0, eo});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual still running required finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[10];
        bit   got;
        tbl[0] = '{255, 12'h255, 1'b0};
        tbl[1] = '{0,   12'h000, 1'b0};
        tbl[2] = '{99,  12'h099, 1'b0};
        tbl[3] = '{100, 12'h100, 1'b0};
        tbl[4] = '{9,   12'h009, 1'b0};
        tbl[5] = '{10,  12'h010, 1'b0};
        tbl[6] = '{128, 12'h128, 1'b0};
        tbl[7] = '{199, 12'h199, 1'b0};
        tbl[8] = '{5,   12'h005, 1'b0};
        tbl[9] = '{50,  12'h050, 1'b0};

        rst = 1'b1; start1 = 1'b0; bin1 = '0; start2 = 1'b0; bin2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_bcd",  {20'd0, bcd1},  32'd0);
        chk("rst_ovf",  {31'd0, ovf1},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table vectors, issued back-to-back (new start in each done cycle).
        for (int i = 0; i < 10; i++) begin
            exp_t e;
            e.bcd = blank_fn(tbl[i].bcd);
            e.ovf = tbl[i].ovf;
            run1(tbl[i].bin, e);
        end

        // start mid-SHIFT is ignored; only the 17 conversion completes.
        @(negedge clk);
        bin1 = 8'd17; start1 = 1'b1; sb.push_back(model(17));
        @(negedge clk);
        start1 = 1'b0; bin1 = 8'd42;
        repeat (3) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; bin1 = 8'd99;
        repeat (25) @(negedge clk);
        chk("ignored_start_sb_empty", sb.size(), 0);
        chk("ignored_start_bcd", {20'd0, bcd1}, {20'd0, blank_fn(12'h017)});

        // Reset in the middle of a conversion of 200.
        bin1 = 8'd200; start1 = 1'b1; sb.push_back(model(200));
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_bcd",  {20'd0, bcd1},  32'd0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_no_done_bcd", {20'd0, bcd1}, 32'd0);
        run1(200, model(200));

        // Exhaustive 0..255 with start held high; dones every 10 cycles.
        last_done  = -1;
        spacing_en = 1'b1;
        bin1   = 8'd0;
        start1 = 1'b1;
        sb.push_back(model(0));
        for (int v = 1; v <= 256; v++) begin
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (done1) got = 1'b1;
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL exh_timeout actual no done required done before bin=%0d", v);
                start1 = 1'b0;
                break;
            end
            if (v < 256) begin
                bin1 = 8'(v);
                sb.push_back(model(v));
            end else begin
                start1 = 1'b0;
            end
        end
        @(negedge clk);
        spacing_en = 1'b0;

        // 10-bit instance: overflow boundary.
        repeat (2) @(negedge clk);
        run2(1000, 12'h000, 1'b1);
        run2(999,  12'h999, 1'b0);
        run2(1023, 12'h023, 1'b1);
        run2(0,    12'h000, 1'b0);

        repeat (15) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
